addsub_serial: RTL and testbench

Parametrised digit-serial adder/subtractor with carry/borrow-in, carry-out and signed-overflow flags, behind valid/ready handshakes on both sides. It processes a WIDTH-bit operation DIGIT bits per cycle, trading latency for a single narrow adder. It sits in the arithmetic library next to the combinational two-bit add/sub-with-carry cells. It serves datapaths where area matters more than throughput.

---
 rtl/addsub_pkg.sv | 30 +++
 rtl/addsub_digit.sv | 26 ++
 rtl/addsub_serial.sv | 157 +++++++++++++++
 tb/tb_addsub_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  // Controller states: waiting for a request, stepping through digits,
  // presenting a result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of digits in one operand. A zero DIGIT is guarded so an illegal
  // parameter set still elaborates far enough to hit the parameter check.
  function automatic int ndig(input int width, input int digit);
    if (digit < 1) return 1;
    return width / digit;
  endfunction

  // Digit counter width; a single-digit operation still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Legal parameter sets: at least one bit per digit, and the operand splits
  // into a whole number of digits.
  function automatic bit params_ok(input int width, input int digit);
    return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational adder slice. Besides the digit sum and carry out it
// exposes the carry into the digit's top bit, which the serial top needs to
// form signed overflow on the most significant digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] full;

  // Widened add so the carry out lands in the extra bit. The carry into the
  // top bit is recovered from the top sum bit: s = a ^ b ^ c, so c = s ^ a ^ b.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(cin);
    sum   = full[DIGIT-1:0];
    cout  = full[DIGIT];
    c_top = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor. A request is latched in IDLE, processed
// DIGIT bits per cycle (LSB digit first) in BUSY through one narrow adder,
// and presented in DONE until the consumer accepts it. Subtraction is folded
// into addition at accept time by inverting the B operand and the carry.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  input  logic             SUB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             V,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] K_LAST = CW'(NDIG - 1);

  // Reject parameter sets that do not split WIDTH into whole digits.
  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("addsub_serial: WIDTH (%0d) must be a multiple of DIGIT (%0d), DIGIT >= 1",
           WIDTH, DIGIT);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // A operand, shifted right one digit per step
  logic [WIDTH-1:0] b_q, b_d;        // effective B (I1 or ~I1), shifted alike
  logic             carry_q, carry_d;
  logic [CW-1:0]    k_q, k_d;        // index of the digit being processed
  logic [WIDTH-1:0] res_q, res_d;    // partial result, filled from the top
  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_ctop;
  logic [WIDTH-1:0] res_shift;

  // The one narrow adder: always works on the lowest digit of the shifting
  // operand registers together with the running carry.
  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_top (dig_ctop)
  );

  // New sum digit enters at the top of the result register while older
  // digits move down; after NDIG steps the LSB digit sits at the bottom.
  // Shifting by DIGIT also covers NDIG = 1, where the sum is the whole result.
  always_comb begin
    res_shift = WIDTH'({dig_sum, res_q} >> DIGIT);
  end

  // Next-state and datapath control for the IDLE/BUSY/DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    res_d   = res_q;
    o_d     = o_q;
    cout_d  = cout_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = I0;
          b_d     = SUB ? ~I1 : I1;
          carry_d = SUB ? ~CIN : CIN;
          k_d     = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        res_d   = res_shift;
        k_d     = k_q + CW'(1);
        if (k_q == K_LAST) begin
          // Last digit: publish the result and flags, leave the counter clean.
          o_d     = res_shift;
          cout_d  = dig_cout;
          v_d     = dig_cout ^ dig_ctop;
          k_d     = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      o_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      res_q   <= res_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  // Handshake flags come from the state register alone, so neither ready nor
  // valid has a combinational path from the opposite side's inputs.
  always_comb begin
    IN_READY  = (state_q == IDLE);
    OUT_VALID = (state_q == DONE);
    O         = o_q;
    COUT      = cout_q;
    V         = v_q;
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: a 16/4 instance for the main
// scenarios and random traffic, plus an 8/8 instance for the single-digit case.
module tb_addsub_serial;

  logic        clk;
  logic        rst_n;

  logic [15:0] i0_16, i1_16, o_16;
  logic        cin_16, sub_16, iv_16, ir_16, c_16, v_16, ov_16, or_16;

  logic [7:0]  i0_8, i1_8, o_8;
  logic        cin_8, sub_8, iv_8, ir_8, c_8, v_8, ov_8, or_8;

  int n_checks;
  int n_errors;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .I0(i0_16), .I1(i1_16), .CIN(cin_16), .SUB(sub_16),
    .IN_VALID(iv_16), .IN_READY(ir_16),
    .O(o_16), .COUT(c_16), .V(v_16),
    .OUT_VALID(ov_16), .OUT_READY(or_16)
  );

  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .I0(i0_8), .I1(i1_8), .CIN(cin_8), .SUB(sub_8),
    .IN_VALID(iv_8), .IN_READY(ir_8),
    .O(o_8), .COUT(c_8), .V(v_8),
    .OUT_VALID(ov_8), .OUT_READY(or_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic on integers. Add is a+b+cin; subtract is a-b-cin.
  // Carry out is "sum reached 2^w" for add and "no borrow" for subtract;
  // overflow is the signed result falling outside the w-bit signed range.
  function automatic void ref_op(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub,
                                 output longint o, output bit c, output bit v);
    longint m, sa, sb, s;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!sub) begin
      o = (a + b + cin) % m;
      c = (a + b + cin) >= m;
      s = sa + sb + cin;
    end else begin
      o = (a - b - cin + m) % m;
      c = a >= (b + cin);
      s = sa - sb - cin;
    end
    v = (s > m / 2 - 1) || (s < -(m / 2));
  endfunction

  // One full transaction on the 16/4 instance. With hold > 0 the consumer
  // stalls for that many cycles in DONE while a stray request is offered.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input bit cin, input bit sub,
                      input logic [15:0] eo, input bit ec, input bit ev, input int hold);
    int lat;
    check({tag, "_in_ready"}, ir_16, 1);
    i0_16 = a; i1_16 = b; cin_16 = cin; sub_16 = sub; iv_16 = 1'b1;
    @(posedge clk); #1;
    iv_16 = 1'b0;
    i0_16 = 16'($urandom); i1_16 = 16'($urandom); cin_16 = 1'($urandom); sub_16 = 1'($urandom);
    lat = 0;
    while (!ov_16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_o"}, o_16, eo);
    check({tag, "_cout"}, c_16, ec);
    check({tag, "_v"}, v_16, ev);
    check({tag, "_busy_in_ready"}, ir_16, 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        iv_16 = 1'b1; i0_16 = 16'hDEAD; i1_16 = 16'hBEEF; sub_16 = ~sub;
      end
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, ov_16, 1);
      check({tag, "_hold_o"}, o_16, eo);
      check({tag, "_hold_in_ready"}, ir_16, 0);
    end
    iv_16 = 1'b0;
    or_16 = 1'b1;
    @(posedge clk); #1;
    or_16 = 1'b0;
    check({tag, "_released_valid"}, ov_16, 0);
    check({tag, "_released_in_ready"}, ir_16, 1);
    check({tag, "_kept_o"}, o_16, eo);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input bit cin, input bit sub,
                     input logic [7:0] eo, input bit ec, input bit ev);
    int lat;
    check({tag, "_in_ready"}, ir_8, 1);
    i0_8 = a; i1_8 = b; cin_8 = cin; sub_8 = sub; iv_8 = 1'b1;
    @(posedge clk); #1;
    iv_8 = 1'b0;
    lat = 0;
    while (!ov_8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_o"}, o_8, eo);
    check({tag, "_cout"}, c_8, ec);
    check({tag, "_v"}, v_8, ev);
    or_8 = 1'b1;
    @(posedge clk); #1;
    or_8 = 1'b0;
    check({tag, "_released_valid"}, ov_8, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint mo;
    bit mc, mv;
    logic [15:0] ra, rb;
    logic [7:0]  sa, sb;
    bit rcin, rsub;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {i0_16, i1_16, cin_16, sub_16, iv_16, or_16} = '0;
    {i0_8, i1_8, cin_8, sub_8, iv_8, or_8} = '0;

    // Reset state, observed while reset is still asserted.
    #1;
    check("rst_in_ready", ir_16, 1);
    check("rst_out_valid", ov_16, 0);
    check("rst_o", o_16, 0);
    check("rst_cout", c_16, 0);
    check("rst_v", v_16, 0);
    check("rst8_in_ready", ir_8, 1);
    check("rst8_out_valid", ov_8, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases on the 16/4 instance.
    op16("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
    op16("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    op16("sub_ovf", 16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);

    // Backpressure with a stray request in DONE, then a back-to-back accept.
    op16("bp_first", 16'h1234, 16'h0034, 1'b0, 1'b1, 16'h1200, 1'b1, 1'b0, 3);
    op16("bp_second", 16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0, 0);

    // Asynchronous reset while digit 2 is pending.
    check("mid_in_ready", ir_16, 1);
    i0_16 = 16'hAAAA; i1_16 = 16'h1111; cin_16 = 1'b0; sub_16 = 1'b0; iv_16 = 1'b1;
    @(posedge clk); #1;
    iv_16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_o", o_16, 0);
    check("mid_rst_cout", c_16, 0);
    check("mid_rst_valid", ov_16, 0);
    check("mid_rst_in_ready", ir_16, 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", ov_16, 0);
    op16("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);

    // Single-digit configuration.
    op8("d8_basic", 8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      if (i % 8 == 0) rb = 16'h8000;
      ref_op(16, longint'(ra), longint'(rb), rcin, rsub, mo, mc, mv);
      op16($sformatf("rnd16_%0d", i), ra, rb, rcin, rsub, 16'(mo), mc, mv,
           int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 20; i++) begin
      sa = 8'($urandom); sb = 8'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      ref_op(8, longint'(sa), longint'(sb), rcin, rsub, mo, mc, mv);
      op8($sformatf("rnd8_%0d", i), sa, sb, rcin, rsub, 8'(mo), mc, mv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
